alu_exec_unit: RTL and testbench

- Execution end of the reservation-station-to-ALU dispatch interface.
- Accepts one ready integer or control-flow micro-op per cycle from the reservation station, computes it, and broadcasts the registered result on the ALU common data bus (CDB) one cycle later.
- Reservation stations, load/store buffer and ROB all snoop the CDB; branches and jumps also report the resolved taken flag and target to the ROB.
- The unit squashes all in-flight work on rollback.

---
 rtl/alu_exec_unit_if.sv | 34 +++
 rtl/alu_exec_unit.sv | 142 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Dispatch/CDB bundle between reservation station, ROB and the ALU execution unit.
// The master side drives dispatch and control; the slave (ALU) side drives the CDB broadcast.
interface alu_exec_unit_if #(
    parameter int ROB_TAG_W = 4,
    parameter int OP_W      = 6
);
    logic                 rdy;
    logic                 rollback;
    logic                 ALU_enable;
    logic [OP_W-1:0]      op_to_ALU;
    logic [31:0]          Vj_to_ALU;
    logic [31:0]          Vk_to_ALU;
    logic [31:0]          imm_to_ALU;
    logic [ROB_TAG_W-1:0] rdTag_to_ALU;
    logic [31:0]          pc_to_ALU;

    logic                 B_ALU_valid;
    logic [31:0]          B_ALU_result;
    logic [ROB_TAG_W-1:0] B_ALU_rdTag;
    logic                 B_ALU_jump;
    logic [31:0]          B_ALU_target;

    modport master (
        output rdy, rollback, ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU,
               imm_to_ALU, rdTag_to_ALU, pc_to_ALU,
        input  B_ALU_valid, B_ALU_result, B_ALU_rdTag, B_ALU_jump, B_ALU_target
    );

    modport slave (
        input  rdy, rollback, ALU_enable, op_to_ALU, Vj_to_ALU, Vk_to_ALU,
               imm_to_ALU, rdTag_to_ALU, pc_to_ALU,
        output B_ALU_valid, B_ALU_result, B_ALU_rdTag, B_ALU_jump, B_ALU_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer/control-flow ALU: computes one dispatched micro-op per cycle and broadcasts it on the CDB.
// One registered stage, no backpressure; rdy=0 freezes the stage, rollback squashes it.
module alu_exec_unit #(
    parameter int ROB_TAG_W = 4,
    parameter int OP_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(1);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(12);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(23);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(25);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(28);

    logic [31:0]          w_opa;
    logic [31:0]          w_opb;
    logic [4:0]           w_shamt;
    logic [31:0]          w_pc4;
    logic [31:0]          w_pc_imm;
    logic [31:0]          w_sum;
    logic                 w_lt_s;
    logic                 w_lt_u;
    logic                 w_eq;
    logic                 w_is_itype;
    logic [31:0]          w_result;
    logic                 w_jump;
    logic [31:0]          w_target;

    logic                 r_valid;
    logic [31:0]          r_result;
    logic [ROB_TAG_W-1:0] r_rdTag;
    logic                 r_jump;
    logic [31:0]          r_target;

    // I-type codes are one contiguous range, so operand B selection is a range test.
    always_comb begin
        w_is_itype = (bus.op_to_ALU >= OP_ADDI) && (bus.op_to_ALU <= OP_SRAI);
        w_opa      = bus.Vj_to_ALU;
        w_opb      = w_is_itype ? bus.imm_to_ALU : bus.Vk_to_ALU;
        w_shamt    = w_opb[4:0];
        w_pc4      = bus.pc_to_ALU + 32'd4;
        w_pc_imm   = bus.pc_to_ALU + bus.imm_to_ALU;
        w_sum      = w_opa + w_opb;
        w_lt_s     = $signed(w_opa) < $signed(w_opb);
        w_lt_u     = w_opa < w_opb;
        w_eq       = w_opa == w_opb;
    end

    always_comb begin
        w_result = 32'd0;
        w_jump   = 1'b0;
        w_target = w_pc4;
        case (bus.op_to_ALU)
            OP_LUI:   w_result = bus.imm_to_ALU;
            OP_AUIPC: w_result = w_pc_imm;
            OP_JAL: begin
                w_result = w_pc4;
                w_jump   = 1'b1;
                w_target = w_pc_imm;
            end
            OP_JALR: begin
                w_result = w_pc4;
                w_jump   = 1'b1;
                w_target = (w_opa + bus.imm_to_ALU) & ~32'd1;
            end
            OP_BEQ:   w_jump = w_eq;
            OP_BNE:   w_jump = !w_eq;
            OP_BLT:   w_jump = w_lt_s;
            OP_BGE:   w_jump = !w_lt_s;
            OP_BLTU:  w_jump = w_lt_u;
            OP_BGEU:  w_jump = !w_lt_u;
            OP_ADDI, OP_ADD:   w_result = w_sum;
            OP_SUB:            w_result = w_opa - w_opb;
            OP_SLTI, OP_SLT:   w_result = {31'd0, w_lt_s};
            OP_SLTIU, OP_SLTU: w_result = {31'd0, w_lt_u};
            OP_XORI, OP_XOR:   w_result = w_opa ^ w_opb;
            OP_ORI, OP_OR:     w_result = w_opa | w_opb;
            OP_ANDI, OP_AND:   w_result = w_opa & w_opb;
            OP_SLLI, OP_SLL:   w_result = w_opa << w_shamt;
            OP_SRLI, OP_SRL:   w_result = w_opa >> w_shamt;
            OP_SRAI, OP_SRA:   w_result = $unsigned($signed(w_opa) >>> w_shamt);
            default: ;
        endcase
        // Branch target is picked after the condition so all six branches share one mux.
        if (bus.op_to_ALU >= OP_BEQ && bus.op_to_ALU <= OP_BGEU && w_jump) begin
            w_target = w_pc_imm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_result <= 32'd0;
            r_rdTag  <= '0;
            r_jump   <= 1'b0;
            r_target <= 32'd0;
        end else if (bus.rollback) begin
            r_valid <= 1'b0;
            r_jump  <= 1'b0;
        end else if (bus.rdy) begin
            r_valid <= bus.ALU_enable;
            r_jump  <= bus.ALU_enable & w_jump;
            if (bus.ALU_enable) begin
                r_result <= w_result;
                r_rdTag  <= bus.rdTag_to_ALU;
                r_target <= w_target;
            end
        end
    end

    assign bus.B_ALU_valid  = r_valid;
    assign bus.B_ALU_result = r_result;
    assign bus.B_ALU_rdTag  = r_rdTag;
    assign bus.B_ALU_jump   = r_jump;
    assign bus.B_ALU_target = r_target;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an in-bench reference model.
module tb_alu_exec_unit;
    localparam int TW = 4;
    localparam int OW = 6;

    typedef struct packed {
        logic [31:0] res;
        logic        jmp;
        logic [31:0] tgt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   cmp_en;

    alu_exec_unit_if #(.ROB_TAG_W(TW), .OP_W(OW)) bus ();

    alu_exec_unit #(.ROB_TAG_W(TW), .OP_W(OW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Straight from the ISA rules: what the CDB must carry for one op.
    function automatic exp_t ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] vk,
                                       input logic [31:0] imm, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] b;
        int unsigned sh;
        bit          cond;
        b     = (op >= 10 && op <= 18) ? imm : vk;
        sh    = b % 32;
        e.res = 0;
        e.jmp = 0;
        e.tgt = pc + 4;
        cond  = 0;
        case (op)
            0: e.res = imm;
            1: e.res = pc + imm;
            2: begin e.res = pc + 4; e.jmp = 1; e.tgt = pc + imm; end
            3: begin e.res = pc + 4; e.jmp = 1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
            4, 5, 6, 7, 8, 9: begin
                case (op)
                    4: cond = (a == b);
                    5: cond = (a != b);
                    6: cond = ($signed(a) < $signed(b));
                    7: cond = ($signed(a) >= $signed(b));
                    8: cond = (a < b);
                    default: cond = (a >= b);
                endcase
                e.jmp = cond;
                if (cond) e.tgt = pc + imm;
            end
            10, 19: e.res = a + b;
            20:     e.res = a - b;
            11, 22: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            12, 23: e.res = (a < b) ? 1 : 0;
            13, 24: e.res = a ^ b;
            14, 25: e.res = a | b;
            15, 26: e.res = a & b;
            16, 21: e.res = a << sh;
            17, 27: e.res = a >> sh;
            18, 28: e.res = $unsigned($signed(a) >>> sh);
            default: ;
        endcase
        return e;
    endfunction

    logic          m_valid;
    logic          m_jknown;
    logic [TW-1:0] m_tag;
    exp_t          m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 0;
            m_jknown <= 1;
            m_tag    <= 0;
            m_exp    <= '0;
        end else if (bus.rollback) begin
            m_valid     <= 0;
            m_jknown    <= 1;
            m_exp.jmp   <= 0;
        end else if (bus.rdy) begin
            if (bus.ALU_enable) begin
                m_valid  <= 1;
                m_jknown <= 1;
                m_tag    <= bus.rdTag_to_ALU;
                m_exp    <= ref_model(bus.op_to_ALU, bus.Vj_to_ALU, bus.Vk_to_ALU, bus.imm_to_ALU, bus.pc_to_ALU);
            end else begin
                m_valid  <= 0;
                m_jknown <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("model_valid", bus.B_ALU_valid, m_valid);
            if (m_valid) begin
                chk("model_result", bus.B_ALU_result, m_exp.res);
                chk("model_tag", bus.B_ALU_rdTag, m_tag);
                chk("model_jump", bus.B_ALU_jump, m_exp.jmp);
                chk("model_target", bus.B_ALU_target, m_exp.tgt);
            end else if (m_jknown) begin
                chk("model_jump_clr", bus.B_ALU_jump, m_exp.jmp);
            end
        end
    end

    task automatic drive(input bit en, input int op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input int tag);
        bus.ALU_enable   = en;
        bus.op_to_ALU    = OW'(op);
        bus.Vj_to_ALU    = vj;
        bus.Vk_to_ALU    = vk;
        bus.imm_to_ALU   = imm;
        bus.pc_to_ALU    = pc;
        bus.rdTag_to_ALU = TW'(tag);
    endtask

    task automatic directed(input string nm, input int op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] imm, input logic [31:0] pc, input int tag,
                            input logic [31:0] eres, input bit ejmp, input logic [31:0] etgt);
        @(negedge clk);
        drive(1, op, vj, vk, imm, pc, tag);
        @(negedge clk);
        bus.ALU_enable = 0;
        chk({nm, "_valid"}, bus.B_ALU_valid, 1);
        chk({nm, "_result"}, bus.B_ALU_result, eres);
        chk({nm, "_tag"}, bus.B_ALU_rdTag, tag);
        chk({nm, "_jump"}, bus.B_ALU_jump, ejmp);
        chk({nm, "_target"}, bus.B_ALU_target, etgt);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        total  = 0;
        bad    = 0;
        cmp_en = 0;
        rst_n  = 0;
        bus.rdy      = 1;
        bus.rollback = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.B_ALU_valid, 0);
        chk("rst_result", bus.B_ALU_result, 0);
        chk("rst_tag", bus.B_ALU_rdTag, 0);
        chk("rst_jump", bus.B_ALU_jump, 0);
        chk("rst_target", bus.B_ALU_target, 0);
        rst_n  = 1;
        cmp_en = 1;

        directed("add_ovf", 19, 32'h7FFF_FFFF, 1, 0, 32'h1000, 3, 32'h8000_0000, 0, 32'h1004);
        chk("add_ovf_next_valid", bus.B_ALU_valid, 1);
        @(negedge clk);
        chk("add_ovf_idle_valid", bus.B_ALU_valid, 0);
        directed("sra", 28, 32'h8000_0010, 32'h24, 0, 32'h20, 1, 32'hF800_0001, 0, 32'h24);
        directed("srl", 27, 32'h8000_0010, 32'h24, 0, 32'h20, 2, 32'h0800_0001, 0, 32'h24);
        directed("sltu", 23, 32'hFFFF_FFFF, 1, 0, 32'h30, 4, 0, 0, 32'h34);
        directed("slt", 22, 32'hFFFF_FFFF, 1, 0, 32'h30, 5, 1, 0, 32'h34);
        directed("blt", 6, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 6, 0, 1, 32'hF8);
        directed("bgeu", 9, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 7, 0, 1, 32'hF8);
        directed("bltu", 8, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF8, 32'h100, 8, 0, 0, 32'h104);
        directed("jalr", 3, 32'h1003, 0, 2, 32'h40, 9, 32'h44, 1, 32'h1004);
        directed("illegal", 45, 32'h1234, 32'h5678, 7, 32'h80, 10, 0, 0, 32'h84);

        // Rollback lands on the second of three back-to-back dispatches.
        @(negedge clk);
        drive(1, 2, 0, 0, 32'h10, 32'h200, 11);
        @(negedge clk);
        chk("rb_op1_valid", bus.B_ALU_valid, 1);
        chk("rb_op1_result", bus.B_ALU_result, 32'h204);
        chk("rb_op1_jump", bus.B_ALU_jump, 1);
        drive(1, 0, 0, 0, 32'hABCD_0000, 32'h300, 12);
        bus.rollback = 1;
        @(negedge clk);
        chk("rb_drop_valid", bus.B_ALU_valid, 0);
        chk("rb_drop_jump", bus.B_ALU_jump, 0);
        bus.rollback = 0;
        drive(1, 24, 32'hF0, 32'hFF, 0, 32'h400, 13);
        @(negedge clk);
        chk("rb_op3_valid", bus.B_ALU_valid, 1);
        chk("rb_op3_result", bus.B_ALU_result, 32'h0F);
        chk("rb_op3_tag", bus.B_ALU_rdTag, 13);
        bus.ALU_enable = 0;

        // rdy low freezes a valid result even with dispatch requested.
        @(negedge clk);
        drive(1, 10, 5, 0, 6, 32'h500, 14);
        @(negedge clk);
        bus.rdy = 0;
        drive(1, 20, 100, 1, 0, 32'h600, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_valid", bus.B_ALU_valid, 1);
            chk("frz_result", bus.B_ALU_result, 11);
            chk("frz_tag", bus.B_ALU_rdTag, 14);
            chk("frz_target", bus.B_ALU_target, 32'h504);
        end
        bus.rdy = 1;
        bus.ALU_enable = 0;

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 40), rnd_val(), rnd_val(), rnd_val(),
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 15));
            bus.rdy      = $urandom_range(0, 9) != 0;
            bus.rollback = $urandom_range(0, 19) == 0;
        end
        @(negedge clk);
        bus.rdy      = 1;
        bus.rollback = 0;

        // Asynchronous reset in the middle of a cycle with a valid result pending.
        drive(1, 2, 0, 0, 32'h40, 32'h700, 15);
        @(posedge clk);
        bus.ALU_enable = 0;
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", bus.B_ALU_valid, 0);
        chk("arst_result", bus.B_ALU_result, 0);
        chk("arst_tag", bus.B_ALU_rdTag, 0);
        chk("arst_jump", bus.B_ALU_jump, 0);
        chk("arst_target", bus.B_ALU_target, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_arst_valid", bus.B_ALU_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
